// File: rtl/serial_io_harness_pkg.sv
// Shared types and frame-size helpers for serial_io_harness.
// SERIAL_IO_HARNESS_MISR_EN appends a 32-bit MISR signature to every output frame.
package serial_io_harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    APPLY,
    WAIT,
    CAPTURE,
    SHIFT_OUT
  } state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  function automatic int unsigned in_len(input int unsigned ports, input int unsigned width,
                                         input int unsigned ctrl_w);
    return ports + ports * width + ctrl_w;
  endfunction

  function automatic int unsigned out_len(input int unsigned ports, input int unsigned width);
`ifdef SERIAL_IO_HARNESS_MISR_EN
    return ports + ports * width + 32;
`else
    return ports + ports * width;
`endif
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] cur, input logic [31:0] fold);
    return {cur[30:0], 1'b0} ^ (cur[31] ? MISR_POLY : 32'h0) ^ fold;
  endfunction

endpackage

// File: rtl/serial_io_harness_shift_reg.sv
// Shift register with serial-in/parallel-out and parallel-load/serial-out (MSB first) use.
module serial_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en_i,
  input  logic         ser_i,
  input  logic         load_en_i,
  input  logic [W-1:0] load_data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_en_i) begin
      data_q <= load_data_i;
    end else if (shift_en_i) begin
      data_q <= {data_q[W-2:0], ser_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_io_harness.sv
// Pin-limited harness: deserialise {push,data,ctrl}, drive the network, reserialise {valid,data}.
// Define SERIAL_IO_HARNESS_MISR_EN to append a running 32-bit MISR to every output frame.
module serial_io_harness
  import serial_io_harness_pkg::*;
#(
  parameter int unsigned PORTS   = 8,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_in,
  input  logic                     ser_in_valid,
  output logic                     ser_out,
  output logic                     ser_out_valid,
  output logic                     busy,
  output logic                     err_overrun,
  output logic [PORTS-1:0]         dut_push,
  output logic [PORTS*WIDTH-1:0]   dut_data_in,
  output logic [CTRL_W-1:0]        dut_control,
  input  logic [PORTS-1:0]         dut_valid,
  input  logic [PORTS*WIDTH-1:0]   dut_data_out
);

  localparam int unsigned DATA_W   = PORTS * WIDTH;
  localparam int unsigned IN_LEN   = in_len(PORTS, WIDTH, CTRL_W);
  localparam int unsigned BASE_LEN = PORTS + DATA_W;
  localparam int unsigned OUT_LEN  = out_len(PORTS, WIDTH);
  localparam int unsigned MAX_LEN  = (IN_LEN > OUT_LEN) ? IN_LEN : OUT_LEN;
  localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);
  localparam int unsigned WCNT_W   = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0]  IN_LAST  = CNT_W'(IN_LEN - 1);
  localparam logic [CNT_W-1:0]  OUT_LAST = CNT_W'(OUT_LEN - 1);
  localparam logic [WCNT_W-1:0] W_LAST   = WCNT_W'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [PORTS-1:0]    push_q, push_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                err_q, err_d;

  logic                in_shift, out_load, out_shift;
  logic [IN_LEN-2:0]   in_frame;
  logic [OUT_LEN-1:0]  out_frame, out_load_val;
  logic                unused_out;

`ifdef SERIAL_IO_HARNESS_MISR_EN
  logic [31:0] misr_q, misr_d, fold;

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < BASE_LEN; i++) begin
      fold[5'(i % 32)] = fold[5'(i % 32)] ^ out_frame[OUT_LEN - BASE_LEN + i];
    end
    misr_d = (state_q == CAPTURE) ? misr_step(misr_q, fold) : misr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misr_q <= MISR_SEED;
    else        misr_q <= misr_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    push_d       = '0;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    err_d        = err_q;
    in_shift     = 1'b0;
    out_load     = 1'b0;
    out_shift    = 1'b0;
    out_load_val = '0;

    case (state_q)
      IDLE: begin
        if (ser_in_valid) begin
          in_shift = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        if (ser_in_valid) begin
          in_shift = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          // Final bit comes straight from the pin so the frame registers load on APPLY entry.
          if (cnt_q == IN_LAST) begin
            {push_d, data_d, ctrl_d} = {in_frame, ser_in};
            state_d = APPLY;
          end
        end
      end
      APPLY: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        // Sampling on WAIT's last edge lands LATENCY cycles after the push cycle;
        // CAPTURE then folds that word into the MISR.
        if (wcnt_q == W_LAST) begin
          out_load = 1'b1;
          out_load_val[OUT_LEN-1 -: BASE_LEN] = {dut_valid, dut_data_out};
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = SHIFT_OUT;
`ifdef SERIAL_IO_HARNESS_MISR_EN
        out_load     = 1'b1;
        out_load_val = {out_frame[OUT_LEN-1 -: BASE_LEN], misr_d};
`endif
      end
      SHIFT_OUT: begin
        out_shift = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == OUT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ser_in_valid && (state_q inside {APPLY, WAIT, CAPTURE, SHIFT_OUT})) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      push_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      push_q  <= push_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end

  serial_shift_reg #(.W(IN_LEN - 1)) u_in_sr (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (in_shift),
    .ser_i      (ser_in),
    .load_en_i  (1'b0),
    .load_data_i('0),
    .data_o     (in_frame)
  );

  serial_shift_reg #(.W(OUT_LEN)) u_out_sr (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (out_shift),
    .ser_i      (1'b0),
    .load_en_i  (out_load),
    .load_data_i(out_load_val),
    .data_o     (out_frame)
  );

  assign unused_out    = ^out_frame[OUT_LEN-2:0];
  assign ser_out_valid = (state_q == SHIFT_OUT);
  assign ser_out       = (state_q == SHIFT_OUT) & out_frame[OUT_LEN-1];
  assign busy          = (state_q != IDLE);
  assign err_overrun   = err_q;
  assign dut_push      = push_q;
  assign dut_data_in   = data_q;
  assign dut_control   = ctrl_q;

endmodule
